vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; successor to the combinational sync decoder.
- Owns the horizontal and vertical counters internally; stepped by a pixel-clock enable.
- Generates registered hsync, vsync, n_blank, n_sync, pixel/line coordinates and frame/line strobes.
- Sits between the clock-enable divider and the pixel pipeline / ADV7123 DAC in the display path.

Parameters:
- CW, 10, width of pixel_x/line_y counters; must hold H_TOTAL-1 and V_TOTAL-1.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, horizontal sync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 11, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BP, 32, vertical back porch (lines).
- H_POL, 0, hsync asserted level (0 = active-low).
- V_POL, 0, vsync asserted level.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  pixel-clock enable; counters advance only when high
- run  in  1  free-run enable; low parks the generator at frame origin
- pixel_x  out  CW  current pixel column, registered
- line_y  out  CW  current line, registered
- hsync  out  1  horizontal sync at H_POL level during sync window
- vsync  out  1  vertical sync at V_POL level during sync window
- n_blank  out  1  high only inside the active area
- n_sync  out  1  tied high; composite sync unused
- line_start  out  1  one-clk pulse at column 0 of every line
- frame_start  out  1  one-clk pulse at column 0, line 0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset: h_cnt = v_cnt = 0; all outputs registered.
  - pixel_x = line_y = 0; hsync = ~H_POL; vsync = ~V_POL.
  - n_blank = 0; line_start = frame_start = 0; n_sync = 1.
- FSM with two states:
  - IDLE (reset state; counters held at 0, outputs at their reset values).
  - RUN, entered on the first clk where run && pix_en.
- RUN, on each clk with pix_en = 1:
  - h_cnt increments; wraps to 0 at H_TOTAL-1.
  - On the h wrap, v_cnt increments; wraps to 0 at V_TOTAL-1.
  - Clocks with pix_en = 0: all state and outputs hold; strobes forced to 0.
- Decode, evaluated on the next-counter values so outputs align with pixel_x/line_y in the same cycle. Output latency is 1 clk from the pix_en edge.
  - hsync asserted when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC (656..751 at defaults).
  - vsync asserted when V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC (491..492).
  - n_blank = (h < H_ACTIVE) && (v < V_ACTIVE).
  - line_start = 1 for the single clk when the registered h becomes 0.
  - frame_start = 1 additionally when v also becomes 0.
- Entering RUN from IDLE:
  - First output cycle is (0,0) with frame_start = line_start = 1 and n_blank = 1.
  - There is no partial frame.
- run deasserted mid-frame:
  - Generator finishes the current frame.
  - At the wrap to (0,0) it returns to IDLE instead of emitting frame_start.
  - run reasserted before the wrap cancels the stop.
- rst_n low at any time: immediate asynchronous return to IDLE and reset values, mid-line or mid-sync included.
- Arithmetic: all comparisons unsigned, CW bits. Boundary constants are computed as localparams; no runtime adders in the compare path.

Decomposition:
- Package vga_pkg:
  - Default 640x480@60 timing localparams.
  - State typedef enum logic {IDLE, RUN} vga_state_t.
  - Function window(v, lo, hi) returning lo ≤ v < hi.
- One sub-module, vga_axis_counter #(CW, TOTAL):
  - Enable-gated wrap counter with a terminal-count output.
  - Instantiated twice: horizontal, and vertical chained on the h terminal count.

Test Plan:
- Reset release, run = 1, pix_en every clk -> first output (0,0): n_blank = 1, frame_start = 1, hsync = vsync = 1.
- Full line at defaults:
  - hsync low exactly for pixel_x 656..751 (96 pix_en cycles).
  - n_blank falls at pixel_x = 640.
  - line_start period = 800 enables.
- Full frame:
  - vsync low exactly for line_y 491..492.
  - frame_start period = 420000 enables; line_y wraps 524 -> 0.
- pix_en = 1 every 2nd clk (50 MHz / 2) -> counts advance only on enabled clks; strobes are 1 clk wide; line = 1600 clks.
- run dropped at line_y = 100 -> frame completes to (799,524); IDLE entered at the wrap; no frame_start; outputs at reset values.
- rst_n pulsed low at pixel_x = 700, line_y = 491 (inside both syncs) -> hsync = vsync = 1, counters 0 asynchronously; clean frame restarts after release.

Source files
------------

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA raster timing generator:
//   - default 640x480@60 timing constants (used as parameter defaults)
//   - vga_state_t : generator state (IDLE parked at origin, RUN scanning)
//   - window()    : half-open range test lo <= v < hi
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int unsigned DEF_CW       = 10;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 11;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } vga_state_t;

    // Bounds are elaboration-time constants, so this reduces to two
    // constant comparators with no adders in the decode path.
    function automatic logic window(input int unsigned v,
                                    input int unsigned lo,
                                    input int unsigned hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// Enable-gated wrap counter for one raster axis. Counts 0..TOTAL-1 and wraps.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (count -> 0)
//   i_en         : advance by one on this clock
//   o_cnt        : registered count
//   o_cnt_next   : value o_cnt takes on the next clock (for aligned decode)
//   o_tc         : terminal count, high while o_cnt == TOTAL-1
// -----------------------------------------------------------------------------
module vga_axis_counter #(
    parameter int unsigned CW    = 10,
    parameter int unsigned TOTAL = 800
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    output logic [CW-1:0] o_cnt,
    output logic [CW-1:0] o_cnt_next,
    output logic          o_tc
);

    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_next;
    logic          w_tc;

    assign w_tc = (r_cnt == LAST);

    always_comb begin
        w_next = r_cnt;
        if (i_en) begin
            w_next = w_tc ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next;
        end
    end

    assign o_cnt      = r_cnt;
    assign o_cnt_next = w_next;
    assign o_tc       = w_tc;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator stepped by a pixel-clock enable.
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   pix_en       : pixel enable; counters and outputs advance only when high
//   run          : free-run enable; when low the current frame completes and
//                  the generator parks at the frame origin
//   pixel_x      : current column (registered)
//   line_y       : current line (registered)
//   hsync, vsync : sync outputs, at H_POL / V_POL level inside the sync window
//   n_blank      : high only inside the active area
//   n_sync       : constant high (composite sync unused)
//   line_start   : one-clock pulse when the column becomes 0
//   frame_start  : one-clock pulse when column and line both become 0
// All decoded outputs are computed from the counters' next values and
// registered, so they line up with pixel_x/line_y in the same cycle.
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CW       = DEF_CW,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        H_POL    = 1'b0,
    parameter logic        V_POL    = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_en,
    input  logic          run,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] line_y,
    output logic          hsync,
    output logic          vsync,
    output logic          n_blank,
    output logic          n_sync,
    output logic          line_start,
    output logic          frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_LO   = H_ACTIVE + H_FP;
    localparam int unsigned HS_HI   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_LO   = V_ACTIVE + V_FP;
    localparam int unsigned VS_HI   = V_ACTIVE + V_FP + V_SYNC;

    vga_state_t    r_state;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_n_blank;
    logic          r_line_start;
    logic          r_frame_start;

    logic [CW-1:0] w_h_cnt;
    logic [CW-1:0] w_h_next;
    logic [CW-1:0] w_v_cnt;
    logic [CW-1:0] w_v_next;
    logic          w_h_tc;
    logic          w_v_tc;
    logic          w_h_step;
    logic          w_v_step;
    logic          w_start;
    logic          w_stop;
    logic          w_load;
    logic          w_hs_on;
    logic          w_vs_on;
    logic          w_active;

    // Counters only move in RUN; the IDLE->RUN clock presents (0,0) itself
    // rather than stepping past it, so the first frame is complete.
    assign w_h_step = (r_state == RUN) && pix_en;
    assign w_v_step = w_h_step && w_h_tc;

    assign w_start  = (r_state == IDLE) && run && pix_en;
    // Stop is only honoured at the frame wrap; run is sampled right there,
    // so reasserting it anywhere earlier cancels a pending stop.
    assign w_stop   = w_v_step && w_v_tc && !run;
    assign w_load   = w_start || (w_h_step && !w_stop);

    assign w_hs_on  = window(32'(w_h_next), HS_LO, HS_HI);
    assign w_vs_on  = window(32'(w_v_next), VS_LO, VS_HI);
    assign w_active = window(32'(w_h_next), 0, H_ACTIVE) &&
                      window(32'(w_v_next), 0, V_ACTIVE);

    vga_axis_counter #(
        .CW    (CW),
        .TOTAL (H_TOTAL)
    ) u_h_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (w_h_step),
        .o_cnt      (w_h_cnt),
        .o_cnt_next (w_h_next),
        .o_tc       (w_h_tc)
    );

    vga_axis_counter #(
        .CW    (CW),
        .TOTAL (V_TOTAL)
    ) u_v_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (w_v_step),
        .o_cnt      (w_v_cnt),
        .o_cnt_next (w_v_next),
        .o_tc       (w_v_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_hsync       <= ~H_POL;
            r_vsync       <= ~V_POL;
            r_n_blank     <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            // Strobes last one clock; any clock without a load clears them.
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;

            unique case (r_state)
                IDLE: if (w_start) r_state <= RUN;
                RUN:  if (w_stop)  r_state <= IDLE;
            endcase

            if (w_load) begin
                r_hsync       <= w_hs_on ? H_POL : ~H_POL;
                r_vsync       <= w_vs_on ? V_POL : ~V_POL;
                r_n_blank     <= w_active;
                r_line_start  <= (w_h_next == '0);
                r_frame_start <= (w_h_next == '0) && (w_v_next == '0);
            end else if (w_stop) begin
                r_hsync       <= ~H_POL;
                r_vsync       <= ~V_POL;
                r_n_blank     <= 1'b0;
            end
        end
    end

    assign pixel_x     = w_h_cnt;
    assign line_y      = w_v_cnt;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign n_blank     = r_n_blank;
    assign n_sync      = 1'b1;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Two generators share clock, reset and pixel enable: a small-timing one
// (30 x 15 raster, 450 enables per frame) so whole frames fit in a short run,
// and one at default 640x480 timing for line-level measurements.
// The reference model tracks the number of enabled clocks since the frame
// origin and derives column/line by division, then applies the window rules.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       nb;
        logic       ns;
        logic       ls;
        logic       fs;
    } obs_t;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
    } tim_t;

    typedef struct {
        logic run;
        logic pix;
        obs_t exp;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic pix_en = 1'b0;
    logic run_s  = 1'b0;
    logic run_d  = 1'b0;

    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    logic [9:0] px_s, ly_s, px_d, ly_d;
    logic hs_s, vs_s, nb_s, ns_s, ls_s, fs_s;
    logic hs_d, vs_d, nb_d, ns_d, ls_d, fs_d;
    obs_t obs_s, obs_d;

    vga_timing_gen #(
        .CW(10), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .H_POL(1'b0), .V_POL(1'b0)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .run(run_s),
        .pixel_x(px_s), .line_y(ly_s), .hsync(hs_s), .vsync(vs_s),
        .n_blank(nb_s), .n_sync(ns_s), .line_start(ls_s), .frame_start(fs_s)
    );

    vga_timing_gen dut_d (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .run(run_d),
        .pixel_x(px_d), .line_y(ly_d), .hsync(hs_d), .vsync(vs_d),
        .n_blank(nb_d), .n_sync(ns_d), .line_start(ls_d), .frame_start(fs_d)
    );

    assign obs_s = {px_s, ly_s, hs_s, vs_s, nb_s, ns_s, ls_s, fs_s};
    assign obs_d = {px_d, ly_d, hs_d, vs_d, nb_d, ns_d, ls_d, fs_d};

    // ---------------- helpers ----------------
    int n_pass  = 0;
    int n_total = 0;

    function automatic obs_t mk(input int x, input int y, input logic hs,
                                input logic vs, input logic nb,
                                input logic ls, input logic fs);
        obs_t o;
        o.x  = 10'(x);
        o.y  = 10'(y);
        o.hs = hs;
        o.vs = vs;
        o.nb = nb;
        o.ns = 1'b1;
        o.ls = ls;
        o.fs = fs;
        return o;
    endfunction

    function automatic obs_t rst_obs();
        return mk(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic int frame_len(input tim_t t);
        return (t.ha + t.hf + t.hs + t.hb) * (t.va + t.vf + t.vs + t.vb);
    endfunction

    // Position reached k enables after the frame origin.
    function automatic obs_t pos_obs(input tim_t t, input int k);
        int htot, vtot, h, v;
        logic in_hs, in_vs;
        htot  = t.ha + t.hf + t.hs + t.hb;
        vtot  = t.va + t.vf + t.vs + t.vb;
        h     = k % htot;
        v     = (k / htot) % vtot;
        in_hs = (h >= t.ha + t.hf) && (h < t.ha + t.hf + t.hs);
        in_vs = (v >= t.va + t.vf) && (v < t.va + t.vf + t.vs);
        return mk(h, v, !in_hs, !in_vs, (h < t.ha) && (v < t.va),
                  h == 0, (h == 0) && (v == 0));
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b nb=%b ns=%b ls=%b fs=%b, want x=%0d y=%0d hs=%b vs=%b nb=%b ns=%b ls=%b fs=%b",
                     name, act.x, act.y, act.hs, act.vs, act.nb, act.ns, act.ls, act.fs,
                     exp.x, exp.y, exp.hs, exp.vs, exp.nb, exp.ns, exp.ls, exp.fs);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    tim_t tm [2];
    logic m_act [2];
    int   m_k   [2];
    obs_t m_exp [2];
    logic chk_on = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] = 1'b0;
                m_k[i]   = 0;
                m_exp[i] = rst_obs();
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic r_in;
                r_in = (i == 0) ? run_s : run_d;
                m_exp[i].ls = 1'b0;
                m_exp[i].fs = 1'b0;
                if (!m_act[i]) begin
                    if (r_in && pix_en) begin
                        m_act[i] = 1'b1;
                        m_k[i]   = 0;
                        m_exp[i] = pos_obs(tm[i], 0);
                    end
                end else if (pix_en) begin
                    m_k[i] = (m_k[i] + 1) % frame_len(tm[i]);
                    if (m_k[i] == 0 && !r_in) begin
                        m_act[i] = 1'b0;
                        m_exp[i] = rst_obs();
                    end else begin
                        m_exp[i] = pos_obs(tm[i], m_k[i]);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_s", obs_s, m_exp[0]);
            check("model_d", obs_d, m_exp[1]);
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge; inputs settle before the next rising edge.
    task automatic drive(input logic r_s, input logic r_d, input logic p);
        run_s  = r_s;
        run_d  = r_d;
        pix_en = p;
        @(negedge clk);
    endtask

    // Step small generator (pix_en=1) until it shows column x (x<0: any)
    // and line y, bounded.
    task automatic wait_pos(input int x, input int y, input logic r_s);
        int ok;
        ok = 0;
        for (int c = 0; c < 1000; c++) begin
            drive(r_s, 1'b1, 1'b1);
            if ((x < 0 || int'(px_s) == x) && int'(ly_s) == y) begin
                ok = 1;
                break;
            end
        end
        check_int($sformatf("reach_%0d_%0d", x, y), ok, 1);
    endtask

    // ---------------- test ----------------
    vec_t vec [8];
    int   ls_d_t[$], fs_s_t[$], ls_s_t[$];

    initial begin
        int hs_lo, hs_min, hs_max, nb_fall, vs_lo, vs_min, vs_max, prev_y;
        int ls_wide, fsn, seen, idle_ok, got;
        logic prev_nb, prev_ls;

        tm[0] = '{16, 4, 6, 4, 8, 2, 2, 3};
        tm[1] = '{640, 16, 96, 48, 480, 11, 2, 32};

        vec[0] = '{1'b0, 1'b1, rst_obs()};
        vec[1] = '{1'b1, 1'b0, rst_obs()};
        vec[2] = '{1'b1, 1'b1, mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1)};
        vec[3] = '{1'b1, 1'b0, mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)};
        vec[4] = '{1'b1, 1'b1, mk(1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)};
        vec[5] = '{1'b0, 1'b1, mk(2, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)};
        vec[6] = '{1'b1, 1'b1, mk(3, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)};
        vec[7] = '{1'b1, 1'b0, mk(3, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)};

        repeat (3) @(negedge clk);
        check("reset_s", obs_s, rst_obs());
        check("reset_d", obs_d, rst_obs());
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // Start-up vectors: idle hold, first (0,0) with strobes, enable gating,
        // run drop mid-frame ignored.
        for (int i = 0; i < 8; i++) begin
            drive(vec[i].run, vec[i].run, vec[i].pix);
            check($sformatf("vec%0d_s", i), obs_s, vec[i].exp);
            check($sformatf("vec%0d_d", i), obs_d, vec[i].exp);
        end

        // Continuous enable: default line timing and small frame timing.
        hs_lo = 0; hs_min = 9999; hs_max = -1; nb_fall = -1;
        vs_lo = 0; vs_min = 9999; vs_max = -1;
        prev_nb = nb_d;
        prev_y  = int'(ly_s);
        for (int c = 0; c < 1600; c++) begin
            drive(1'b1, 1'b1, 1'b1);
            if (ls_d) ls_d_t.push_back(c);
            if (int'(ly_d) == 0 && !hs_d) begin
                hs_lo++;
                if (int'(px_d) < hs_min) hs_min = int'(px_d);
                if (int'(px_d) > hs_max) hs_max = int'(px_d);
            end
            if (prev_nb && !nb_d && nb_fall < 0) nb_fall = int'(px_d);
            prev_nb = nb_d;
            if (fs_s) begin
                fs_s_t.push_back(c);
                check_int("y_wrap_from", prev_y, 14);
            end
            if (fs_s_t.size() == 1 && !vs_s) begin
                vs_lo++;
                if (int'(ly_s) < vs_min) vs_min = int'(ly_s);
                if (int'(ly_s) > vs_max) vs_max = int'(ly_s);
            end
            prev_y = int'(ly_s);
        end
        check_int("hsync_low_cycles", hs_lo, 96);
        check_int("hsync_first_x", hs_min, 656);
        check_int("hsync_last_x", hs_max, 751);
        check_int("nblank_fall_x", nb_fall, 640);
        check_int("ls_d_count", ls_d_t.size(), 2);
        if (ls_d_t.size() >= 2) check_int("line_period_d", ls_d_t[1] - ls_d_t[0], 800);
        check_int("fs_s_count", fs_s_t.size(), 3);
        if (fs_s_t.size() >= 2) check_int("frame_period_s", fs_s_t[1] - fs_s_t[0], 450);
        check_int("vsync_low_cycles", vs_lo, 60);
        check_int("vsync_first_y", vs_min, 10);
        check_int("vsync_last_y", vs_max, 11);

        // Enable every second clock: line takes 60 clocks, strobes stay 1 clk.
        ls_wide = 0;
        prev_ls = 1'b0;
        for (int c = 0; c < 200; c++) begin
            drive(1'b1, 1'b1, (c % 2) == 0);
            if (ls_s) ls_s_t.push_back(c);
            if (ls_s && prev_ls) ls_wide++;
            prev_ls = ls_s;
        end
        check_int("ls_width_half_rate", ls_wide, 0);
        if (ls_s_t.size() >= 2) check_int("line_period_half_rate", ls_s_t[1] - ls_s_t[0], 60);
        else check_int("ls_count_half_rate", ls_s_t.size(), 3);

        // Run dropped on line 3: frame finishes, then parks without frame_start.
        wait_pos(-1, 3, 1'b1);
        seen = 0; fsn = 0; idle_ok = 0;
        for (int c = 0; c < 600; c++) begin
            drive(1'b0, 1'b1, 1'b1);
            if (seen != 0) begin
                check("idle_after_wrap", obs_s, rst_obs());
                idle_ok = 1;
                break;
            end
            if (fs_s) fsn++;
            if (int'(px_s) == 29 && int'(ly_s) == 14) seen = 1;
        end
        check_int("stop_reached", idle_ok, 1);
        check_int("no_fs_on_stop", fsn, 0);
        repeat (20) drive(1'b0, 1'b1, 1'b1);
        check("idle_hold", obs_s, rst_obs());

        // Restart, drop run, reassert before the wrap: stop is cancelled.
        drive(1'b1, 1'b1, 1'b1);
        check("restart_after_idle", obs_s, mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
        wait_pos(-1, 5, 1'b1);
        wait_pos(-1, 12, 1'b0);
        got = 0;
        for (int c = 0; c < 500; c++) begin
            drive(1'b1, 1'b1, 1'b1);
            if (fs_s) begin
                got = 1;
                break;
            end
        end
        check_int("cancel_keeps_running", got, 1);

        // Asynchronous reset inside both sync windows.
        wait_pos(22, 10, 1'b1);
        check_int("in_both_syncs", int'({hs_s, vs_s}), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_s", obs_s, rst_obs());
        check("async_rst_d", obs_d, rst_obs());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
        check("post_rst_start_s", obs_s, mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
        check("post_rst_start_d", obs_d, mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
        fsn = 0;
        for (int c = 0; c < 450; c++) begin
            drive(1'b1, 1'b1, 1'b1);
            if (fs_s) fsn++;
        end
        check_int("clean_frame_fs", fsn, 1);

        // Random enable pattern with occasional run toggles, model-checked.
        for (int c = 0; c < 6000; c++) begin
            logic rs, rd;
            rs = run_s;
            rd = run_d;
            if ($urandom_range(0, 299) == 0) rs = ~rs;
            if ($urandom_range(0, 999) == 0) rd = ~rd;
            drive(rs, rd, $urandom_range(0, 3) != 0);
        end

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
